// File: rtl/morse_player.sv
// morse_player: latches a pattern of 2-bit Morse symbols and plays it with unit timing.
// Optional MORSE_REPEAT_EN adds the rpt input and a word gap before each automatic replay.
module morse_player #(
  parameter int NSYM        = 5,
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [2*NSYM-1:0]                         pattern,
`ifdef MORSE_REPEAT_EN
  input  logic                                      rpt,
`endif
  output logic                                      busy,
  output logic                                      done,
  output logic                                      tone_on,
  output logic                                      short,
  output logic                                      long,
  output logic [(NSYM > 1 ? $clog2(NSYM) : 1)-1:0]  sym_idx
);
  localparam int IW = NSYM > 1 ? $clog2(NSYM) : 1;
  localparam int JW = $clog2(NSYM + 1);
  localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] C1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] C2 = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] C3 = CW'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_REPEAT_EN
  localparam logic [CW-1:0] C6 = CW'(6 * UNIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, TONE, GAP, SPACE, WORD} state_t;
`else
  typedef enum logic [1:0] {IDLE, TONE, GAP, SPACE} state_t;
`endif

  state_t            state_q, state_d, end_st;
  logic [CW-1:0]     cnt_q, cnt_d, end_cnt;
  logic [JW-1:0]     idx_q, idx_d, fidx;
  logic [2*NSYM-1:0] shadow_q, shadow_d, src;
  logic              busy_q, busy_d, done_q, done_d, tone_q, tone_d;
  logic              short_q, short_d, long_q, long_d;
  logic              wrap, silent, restart, fetch;
  logic [1:0]        sym;

  always_comb begin
`ifdef MORSE_REPEAT_EN
    restart = state_q == WORD;
    silent  = state_q == GAP || state_q == SPACE || state_q == WORD;
`else
    restart = 1'b0;
    silent  = state_q == GAP || state_q == SPACE;
`endif
    src   = state_q == IDLE ? pattern : shadow_q;
    fidx  = (state_q == IDLE || restart) ? '0 : idx_q + JW'(1);
    // Shifting past the last slot yields 00, so idx == NSYM reads as end of pattern.
    sym   = 2'(src >> {fidx, 1'b0});
    fetch = (state_q == IDLE && start) || (silent && cnt_q == '0);
`ifdef MORSE_REPEAT_EN
    wrap    = rpt && fidx != '0;
    end_st  = wrap ? WORD : IDLE;
    end_cnt = wrap ? C6 : '0;
`else
    wrap    = 1'b0;
    end_st  = IDLE;
    end_cnt = '0;
`endif
    state_d  = state_q;
    cnt_d    = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    idx_d    = idx_q;
    shadow_d = state_q == IDLE && start ? pattern : shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    short_d  = short_q;
    long_d   = long_q;
    if (state_q == TONE && cnt_q == '0) begin
      state_d = GAP;
      cnt_d   = C1;
      short_d = 1'b0;
      long_d  = 1'b0;
    end
    if (fetch) begin
      idx_d   = sym == 2'b00 ? '0 : fidx;
      short_d = sym == 2'b01;
      long_d  = sym == 2'b10;
      state_d = sym == 2'b00 ? end_st : sym == 2'b11 ? SPACE : TONE;
      cnt_d   = sym == 2'b01 ? C1 : sym == 2'b10 ? C3 : sym == 2'b11 ? C2 : end_cnt;
      busy_d  = sym != 2'b00 || wrap;
      done_d  = sym == 2'b00 && !wrap;
    end
    tone_d = short_d | long_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tone_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tone_q   <= tone_d;
      short_q  <= short_d;
      long_q   <= long_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign tone_on = tone_q;
  assign short   = short_q;
  assign long    = long_q;
  assign sym_idx = IW'(idx_q);
endmodule

// File: tb/tb_morse_player.sv
// tb_morse_player: randomized pattern playback checked cycle by cycle against a queued reference.
module tb_morse_player;
  localparam int NSYM = 4;
  localparam int U    = 4;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] pattern = '0;
  logic       busy, done, tone_on, short, long;
  logic [1:0] sym_idx;
`ifdef MORSE_REPEAT_EN
  logic       rpt = 1'b0;
`endif
  int         checks = 0, failures = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  morse_player #(.NSYM(NSYM), .UNIT_CYCLES(U)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
`ifdef MORSE_REPEAT_EN
    .rpt(rpt),
`endif
    .busy(busy), .done(done), .tone_on(tone_on), .short(short), .long(long), .sym_idx(sym_idx)
  );

  function automatic logic [6:0] vec(bit b, bit d, bit s, bit l, int i);
    return {b, d, s | l, s, l, 2'(i)};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {busy,done,tone,short,long,idx}=%b expected %b", name, $time, got, exp);
    end
  endtask

  // Expected output per cycle for one pass, starting the cycle after the accepting edge.
  task automatic play(input logic [7:0] p, input bit wrap, output int len);
    logic [1:0] s;
    int on, off;
    len = 0;
    for (int i = 0; i < NSYM; i++) begin
      s = p[2*i +: 2];
      if (s == 2'b00) break;
      on  = s == 2'b01 ? U : s == 2'b10 ? 3 * U : 0;
      off = s == 2'b11 ? 2 * U : U;
      repeat (on) exp_q.push_back(vec(1, 0, s == 2'b01, s == 2'b10, i));
      repeat (off) exp_q.push_back(vec(1, 0, 0, 0, i));
      len += on + off;
    end
    if (wrap && len > 0) begin
      repeat (6 * U) exp_q.push_back(vec(1, 0, 0, 0, 0));
      len += 6 * U;
    end else begin
      exp_q.push_back(vec(0, 1, 0, 0, 0));
      len++;
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 7'b0;
    check("cycle", {busy, done, tone_on, short, long, sym_idx}, e);
  end

  // Start on the next edge, then scramble start/pattern while playing (incl. the done edge).
  task automatic txn(input logic [7:0] p);
    int len;
    @(negedge clk);
    start = 1'b1;
    pattern = p;
    @(posedge clk);
    play(p, 1'b0, len);
    for (int k = 1; k < len; k++) begin
      @(negedge clk);
      start = 1'($urandom);
      pattern = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int len;
    logic [7:0] p;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(2);
    txn(8'b00_00_10_01);
    idle(1);
    txn(8'b01_11_01_01);
    idle(2);
    txn(8'h00);
    txn(8'b00_10_11_10);
    txn(8'b10_10_10_10);
    for (int n = 0; n < 150; n++) begin
      p = 8'($urandom);
      if ($urandom_range(7) == 0) p = 8'h00;
      txn(p);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    idle(1);
    @(negedge clk);
    start = 1'b1;
    pattern = 8'b00_00_00_10;
    @(posedge clk);
    play(8'b00_00_00_10, 1'b0, len);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("reset_cut", {busy, done, tone_on, short, long, sym_idx}, 7'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(3);
    txn(8'b00_00_11_01);
    idle(2);
`ifdef MORSE_REPEAT_EN
    rpt = 1'b1;
    txn(8'h00);
    idle(1);
    @(negedge clk);
    start = 1'b1;
    pattern = 8'b00_00_00_01;
    @(posedge clk);
    play(8'b00_00_00_01, 1'b1, len);
    play(8'b00_00_00_01, 1'b1, len);
    play(8'b00_00_00_01, 1'b0, len);
    @(negedge clk);
    start = 1'b0;
    repeat (65) @(posedge clk);
    @(negedge clk);
    rpt = 1'b0;
    idle(12);
`endif
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morse_player.md
# morse_player

Parametrised Morse pattern sequencer. It takes a packed pattern of NSYM two-bit symbols, latches it on a start handshake, and plays it symbol by symbol with standard Morse unit timing. Outputs are registered tone_on/short/long strobes that feed the sound module and the audio DAC path. It replaces the fixed 10-bit register-plus-decompose pair in the processor top and adds variable length, letter gaps, a busy/done handshake and optional auto-repeat.

## Interface
- NSYM, 5: number of symbol slots in the pattern (≥1).
- UNIT_CYCLES, 12500000: clocks per Morse unit (≥1); 250 ms at 50 MHz.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- pattern  in  2*NSYM  symbol i is at bits [2i+1:2i]. 00 = end, 01 = dot, 10 = dash, 11 = letter space.
- repeat  in  1  loop enable; present only with MORSE_REPEAT_EN.
- busy  out  1  high while a pattern is playing.
- done  out  1  one-cycle pulse at the end of playback.
- tone_on  out  1  tone request (dot or dash active).
- short  out  1  high during a dot tone.
- long  out  1  high during a dash tone.
- sym_idx  out  clog2(NSYM)  index of the symbol currently playing; 0 when idle.

## Operation
- States: IDLE, TONE, GAP, SPACE, and WORD (WORD exists only with the macro).
- Timing counter is wide enough for 7*UNIT_CYCLES. It loads the duration minus 1 and counts down to 0.
- IDLE, start=1: copy pattern into a shadow register; idx=0; fetch symbol 0.
- Fetch symbol at idx:
  - 01 → TONE for U cycles, short=1.
  - 10 → TONE for 3U cycles, long=1.
  - 11 → SPACE for 2U cycles (silent).
  - 00, or idx == NSYM → end of pattern.
- TONE expires → GAP for U cycles, all tone outputs low.
- GAP or SPACE expires → idx+1, then fetch.
- End of pattern → done=1 for one cycle, busy=0, go to IDLE.
- start while not in IDLE is ignored.
- Changes on pattern after latch are ignored; only the shadow register is used.
- Empty pattern (symbol 0 = 00): done pulses on the accepting edge and busy never rises.
- Reset forces all outputs to 0, state to IDLE and the shadow register to 0.
- Reset takes effect immediately mid-tone; the tone is cut in the same cycle.

## Timing
- Start accepted at edge E0: busy, tone_on, short/long and sym_idx are valid after E0 (zero-cycle registered latency).
- Dot: tone_on high for exactly U cycles, then low for U cycles.
- Dash: high for 3U cycles, then low for U cycles.
- Letter space: low for 2U cycles, for 3U total with the preceding gap.
- The next symbol's outputs appear on the edge where the previous gap or space expires.
- done is high for one cycle, starting at the edge where the final gap expires. busy falls on that same edge.
- start asserted on that edge is ignored. start asserted one cycle later is accepted.
- short and long are never both high. tone_on == short|long.

## Configuration
- MORSE_REPEAT_EN defined:
  - The repeat port exists.
  - If repeat=1 at end of pattern: enter WORD for 6U cycles (7U silence including the last gap), then replay from idx 0 with the same shadow pattern. No done pulse; busy stays 1.
  - Deasserting repeat lets the current pass finish, then done pulses.
  - An empty pattern with repeat=1 still finishes immediately with done.
- MORSE_REPEAT_EN undefined: no repeat port, no WORD state. Behaviour is identical to repeat=0.

## Test plan
All scenarios use NSYM=4, UNIT_CYCLES=4.
- Reset release → busy, done, tone_on, short, long = 0; sym_idx = 0.
- pattern=8'b00_00_10_01, start pulse → short for 4 cycles, silent 4, long for 12, silent 4. done pulses 24 cycles after E0; sym_idx steps 0→1.
- pattern=8'b01_11_01_01 → dot, gap, dot, gap, space 8, dot, gap. done at cycle 32; sym_idx reaches 3 and no fetch happens past NSYM.
- pattern=0 with start → done pulses on the next edge, busy stays 0.
- Mid-play: start toggled and pattern changed to 8'hFF → playback is unchanged. reset asserted mid-dash → all outputs 0 in the same cycle, state IDLE after release.
- With MORSE_REPEAT_EN, repeat=1, pattern=8'b00_00_00_01 → dot 4, silent 28, dot 4, and so on with no done. Dropping repeat → done 8 cycles after the current dot starts.
